queue_uart_tx: RTL and testbench

//  Read side of the 16x8 byte queue: pops bytes one at a time and sends each as a UART frame, LSB first.

---
 rtl/queue_uart_pkg.sv | 16 +
 rtl/uart_baud_tick.sv | 39 +++
 rtl/queue_uart_tx.sv | 189 ++++++++++++++++++
 tb/tb_queue_uart_tx.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/queue_uart_pkg.sv
// Shared constants for the queue-to-UART transmit path.
//   - Default baud divider and data width.
//   - FSM state encoding used by queue_uart_tx.
package queue_uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 868;  // 115200 baud at 100 MHz
    localparam int DATA_W_DEF       = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;
    localparam logic [2:0] ST_STOP   = 3'd5;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time generator for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 and wraps; tick is high on the last count of
// each bit time. clr holds the counter at zero so a bit time starts cleanly.
// Ports:
//   clk   in   clock, rising edge
//   rst_n in   asynchronous active-low reset
//   clr   in   hold counter at zero
//   tick  out  1-cycle pulse on last clock of each bit time
//   cnt   out  current count within the bit time
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    output logic             tick,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_r;

    // Bit-time counter: cleared on request, otherwise wraps at LAST_CNT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr || (cnt_r == LAST_CNT)) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    assign tick = (cnt_r == LAST_CNT) & ~clr;
    assign cnt  = cnt_r;

endmodule

// File: rtl/queue_uart_tx.sv
// Read side of the 16x8 byte queue: pops one byte at a time and sends it
// as a UART frame (start, data LSB first, [parity], stop).
// Optional feature macro: QUEUE_UART_TX_PARITY_EN adds an even-parity bit
// after the data bits (11-bit frame); without it frames are 8N1.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   tx_en    in   permit starting new frames
//   q_empty  in   queue empty flag
//   q_dout   in   queue read data, valid the cycle after q_rd_en
//   q_rd_en  out  pop strobe, one cycle per byte, only asserted in IDLE
//   tx       out  serial line, idle high (registered)
//   busy     out  high from FETCH through the end of STOP (registered)
//   tx_done  out  pulse on the last cycle of the stop bit (registered)
module queue_uart_tx
    import queue_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_W       = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_en,
    input  logic              q_empty,
    input  logic [DATA_W-1:0] q_dout,
    output logic              q_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_W) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
    // Count value one cycle before the end of a bit time.
    localparam logic [CNT_W-1:0] PRE_LAST_CNT = CNT_W'(CLKS_PER_BIT - 2);
`ifdef QUEUE_UART_TX_PARITY_EN
    localparam logic [2:0] ST_AFTER_DATA = ST_PARITY;
`else
    localparam logic [2:0] ST_AFTER_DATA = ST_STOP;
`endif

`ifdef QUEUE_UART_TX_PARITY_EN
    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
`endif

    logic [2:0]        state_r, state_s;
    logic [DATA_W-1:0] shift_r, shift_s;
    logic [IDX_W-1:0]  bit_idx_r, bit_idx_s;
    logic              pop_s;
    logic              line_s;
    logic              tx_r, busy_r, tx_done_r;
    logic              baud_clr_s, baud_tick_s;
    logic [CNT_W-1:0]  baud_cnt_s;
`ifdef QUEUE_UART_TX_PARITY_EN
    logic              parity_r;
`endif

    // Bit timer runs only while a frame is on the line.
    assign baud_clr_s = (state_r == ST_IDLE) || (state_r == ST_FETCH);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (baud_clr_s),
        .tick  (baud_tick_s),
        .cnt   (baud_cnt_s)
    );

    // Next-state, shift register and bit counter logic.
    always_comb begin
        state_s   = state_r;
        shift_s   = shift_r;
        bit_idx_s = bit_idx_r;
        pop_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                pop_s = tx_en & ~q_empty;
                if (pop_s) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                shift_s   = q_dout;
                bit_idx_s = '0;
                state_s   = ST_START;
            end
            ST_START: begin
                if (baud_tick_s) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (baud_tick_s) begin
                    shift_s   = {1'b0, shift_r[DATA_W-1:1]};
                    bit_idx_s = bit_idx_r + 1'b1;
                    if (bit_idx_r == LAST_IDX) begin
                        state_s = ST_AFTER_DATA;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
`ifdef QUEUE_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_tick_s) begin
                    state_s = ST_STOP;
                end else begin
                    state_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (baud_tick_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Line level for the upcoming cycle, so tx can be a plain register
    // and still fall the cycle right after FETCH.
    always_comb begin
        case (state_s)
            ST_START: line_s = 1'b0;
            ST_DATA:  line_s = shift_s[0];
`ifdef QUEUE_UART_TX_PARITY_EN
            ST_PARITY: line_s = parity_r;
`endif
            default:  line_s = 1'b1;
        endcase
    end

    // FSM state, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            shift_r   <= '0;
            bit_idx_r <= '0;
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
            tx_done_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            shift_r   <= shift_s;
            bit_idx_r <= bit_idx_s;
            tx_r      <= line_s;
            busy_r    <= (state_s != ST_IDLE);
            // Next cycle is the final clock of the stop bit.
            tx_done_r <= (state_r == ST_STOP) && (baud_cnt_s == PRE_LAST_CNT);
        end
    end

`ifdef QUEUE_UART_TX_PARITY_EN
    // Parity of the byte captured in FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_r <= 1'b0;
        end else if (state_r == ST_FETCH) begin
            parity_r <= even_parity(q_dout);
        end else begin
            parity_r <= parity_r;
        end
    end
`endif

    // Pop is gated by reset so the queue is never popped while held in reset.
    assign q_rd_en = pop_s & rst_n;
    assign tx      = tx_r;
    assign busy    = busy_r;
    assign tx_done = tx_done_r;

endmodule

// File: tb/tb_queue_uart_tx.sv
// Self-checking bench for queue_uart_tx with CLKS_PER_BIT=4.
// A behavioural 16x8 queue feeds the DUT; a frame-level model predicts
// tx/busy/tx_done/q_rd_en each cycle from the bytes pushed into the queue.
module tb_queue_uart_tx;

    localparam int CPB = 4;
    localparam int DW  = 8;
`ifdef QUEUE_UART_TX_PARITY_EN
    localparam int NBITS   = DW + 3;
    localparam int LIT_LEN = 44;
`else
    localparam int NBITS   = DW + 2;
    localparam int LIT_LEN = 40;
`endif

    typedef struct packed {
        logic tx;
        logic busy;
        logic done;
    } exp_t;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          tx_en   = 1'b0;
    logic          q_empty = 1'b1;
    logic [DW-1:0] q_dout  = '0;
    logic          q_rd_en, tx, busy, tx_done;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;
    int sent_idx = 0;

    logic [DW-1:0] fifo[$];
    logic [DW-1:0] pend[$];
    logic [DW-1:0] sent[$];
    exp_t          exp_q[$];

    queue_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_en   (tx_en),
        .q_empty (q_empty),
        .q_dout  (q_dout),
        .q_rd_en (q_rd_en),
        .tx      (tx),
        .busy    (busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Behavioural 16-entry queue with registered read data.
    always @(posedge clk) begin
        if (q_rd_en) begin
            pops <= pops + 1;
            chk("no_underflow", 32'(fifo.size() != 0), 32'd1);
            if (fifo.size() != 0) q_dout <= fifo.pop_front();
        end
        while (pend.size() > 0 && fifo.size() < 16) begin
            fifo.push_back(pend[0]);
            sent.push_back(pend[0]);
            void'(pend.pop_front());
        end
        q_empty <= (fifo.size() == 0);
    end

    // Frame-level model: idle unless a frame is queued up; a pop expands
    // into one FETCH cycle followed by NBITS bit times.
    task automatic model_step();
        exp_t          e;
        logic          erd;
        logic          v;
        logic [DW-1:0] b;
        if (!rst_n) begin
            exp_q.delete();
            e   = '{1'b1, 1'b0, 1'b0};
            erd = 1'b0;
        end else if (exp_q.size() == 0) begin
            e   = '{1'b1, 1'b0, 1'b0};
            erd = tx_en && !q_empty;
        end else begin
            e   = exp_q.pop_front();
            erd = 1'b0;
        end
        chk("tx", 32'(tx), 32'(e.tx));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("tx_done", 32'(tx_done), 32'(e.done));
        chk("q_rd_en", 32'(q_rd_en), 32'(erd));
        if (erd && sent_idx < sent.size()) begin
            b = sent[sent_idx];
            sent_idx++;
            exp_q.push_back('{1'b1, 1'b1, 1'b0});
            for (int k = 0; k < NBITS; k++) begin
                if (k == 0)               v = 1'b0;
                else if (k <= DW)         v = b[k-1];
                else if (k == NBITS - 1)  v = 1'b1;
                else                      v = ^b;
                for (int c = 0; c < CPB; c++)
                    exp_q.push_back('{v, 1'b1, (k == NBITS - 1) && (c == CPB - 1)});
            end
        end
    endtask

    always @(negedge clk) model_step();

    // Wait for a start bit, sample mid-bit, stop on tx_done.
    // waited = tx-high cycles seen before the start bit.
    task automatic capture_frame(output logic [15:0] bits, output int len, output int waited);
        int t;
        bits = '0;
        len = 0;
        t = 0;
        @(negedge clk);
        while (tx !== 1'b0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        waited = t;
        if (tx !== 1'b0) begin
            chk("start_timeout", 32'd0, 32'd1);
            return;
        end
        for (int i = 0; i < 200; i++) begin
            if ((i % CPB == CPB / 2) && (i / CPB < 16)) bits[i/CPB] = tx;
            if (tx_done === 1'b1) begin
                len = i + 1;
                return;
            end
            @(negedge clk);
        end
        chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] bits;
        logic [7:0]  burst[3];
        int          len, w, p0, k;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(tx_done), 32'd0);
        chk("rst_rd", 32'(q_rd_en), 32'd0);
        rst_n = 1'b1;
        step(5);

        // Single byte 0xA5
        tx_en = 1'b1;
        p0 = pops;
        pend.push_back(8'hA5);
        capture_frame(bits, len, w);
`ifdef QUEUE_UART_TX_PARITY_EN
        chk("a5_bits", 32'(bits[10:0]), 32'(11'b10101001010));
`else
        chk("a5_bits", 32'(bits[9:0]), 32'(10'b1101001010));
`endif
        chk("a5_len", 32'(len), 32'(LIT_LEN));
        step(3);
        chk("a5_pops", 32'(pops - p0), 32'd1);

        // Burst of three bytes
        burst[0] = 8'h00;
        burst[1] = 8'hFF;
        burst[2] = 8'h3C;
        p0 = pops;
        for (int i = 0; i < 3; i++) pend.push_back(burst[i]);
        for (int i = 0; i < 3; i++) begin
            capture_frame(bits, len, w);
            chk("burst_data", 32'(bits[8:1]), 32'(burst[i]));
            chk("burst_len", 32'(len), 32'(LIT_LEN));
            if (i > 0) chk("burst_gap", 32'(CPB + w), 32'd6);
        end
        step(3);
        chk("burst_pops", 32'(pops - p0), 32'd3);

        // tx_en low holds queued bytes
        tx_en = 1'b0;
        p0 = pops;
        pend.push_back(8'h5A);
        pend.push_back(8'hC3);
        step(40);
        chk("hold_pops", 32'(pops - p0), 32'd0);
        chk("hold_tx", 32'(tx), 32'd1);
        chk("hold_busy", 32'(busy), 32'd0);
        tx_en = 1'b1;
        capture_frame(bits, len, w);
        chk("hold_data", 32'(bits[8:1]), 32'h5A);
        step(10);
        tx_en = 1'b0;
        chk("drop_busy", 32'(busy), 32'd1);
        pend.push_back(8'h99);
        step(60);
        chk("drop_pops", 32'(pops - p0), 32'd2);
        chk("drop_busy_end", 32'(busy), 32'd0);
        chk("drop_held", 32'(q_empty), 32'd0);
        tx_en = 1'b1;
        step(60);

        // Empty guard
        p0 = pops;
        step(100);
        chk("empty_pops", 32'(pops - p0), 32'd0);
        chk("empty_busy", 32'(busy), 32'd0);

        // Reset mid-frame (0x00 keeps the line low through the data bits)
        pend.push_back(8'h00);
        step(20);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rd", 32'(q_rd_en), 32'd0);
        step(2);
        rst_n = 1'b1;
        p0 = pops;
        step(30);
        chk("postrst_pops", 32'(pops - p0), 32'd0);
        chk("postrst_busy", 32'(busy), 32'd0);

`ifdef QUEUE_UART_TX_PARITY_EN
        pend.push_back(8'h07);
        capture_frame(bits, len, w);
        chk("par07_bit", 32'(bits[9]), 32'd1);
        chk("par07_len", 32'(len), 32'd44);
        pend.push_back(8'h03);
        capture_frame(bits, len, w);
        chk("par03_bit", 32'(bits[9]), 32'd0);
        step(3);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 19) == 0 && (fifo.size() + pend.size()) < 15)
                pend.push_back(8'($urandom));
            if ($urandom_range(0, 49) == 0) tx_en = ~tx_en;
            step(1);
        end
        tx_en = 1'b1;
        k = 0;
        while ((fifo.size() > 0 || pend.size() > 0 || busy) && k < 5000) begin
            step(1);
            k++;
        end
        step(5);
        chk("drain_empty", 32'(fifo.size() + pend.size()), 32'd0);
        chk("drain_busy", 32'(busy), 32'd0);
        chk("model_consumed", 32'(sent_idx), 32'(sent.size()));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
